// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code image of the count.
// Ports: clk, rst (async high), en, up, load, load_val -> gray, bin, wrap.
module gray_counter #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAXV = '1;
    localparam logic [WIDTH-1:0] RST_GRAY =
        RESET_VAL ^ (RESET_VAL >> 1);

    logic [WIDTH-1:0] bin_nxt;
    logic [WIDTH-1:0] gray_nxt;
    logic             wrap_nxt;

    // load beats en; wrap only flags a counting step
    always_comb begin
        bin_nxt  = bin;
        wrap_nxt = 1'b0;
        if (load) begin
            bin_nxt = load_val;
        end else if (en) begin
            if (up) begin
                bin_nxt  = bin + ONE;
                wrap_nxt = (bin == MAXV);
            end else begin
                bin_nxt  = bin - ONE;
                wrap_nxt = (bin == '0);
            end
        end
    end

    // Gray derived from the next binary value so both
    // registers always describe the same count
    assign gray_nxt = bin_nxt ^ (bin_nxt >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin  <= RESET_VAL;
            gray <= RST_GRAY;
            wrap <= 1'b0;
        end else begin
            bin  <= bin_nxt;
            gray <= gray_nxt;
            wrap <= wrap_nxt;
        end
    end

endmodule
